// File: rtl/freq_report_tx_pkg.sv
// Shared definitions for the frequency report transmitter: state encoding,
// ASCII constants, widths and the BCD helper functions.
package freq_report_tx_pkg;

    localparam int CNT_W      = 32;
    localparam int NUM_DIGITS = 10;
    localparam int BCD_W      = 4 * NUM_DIGITS;
    localparam int IDX_W      = 4;

    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CONV      = 3'd1,
        ST_SEND_REQ  = 3'd2,
        ST_SEND_WAIT = 3'd3,
        ST_SEND_DONE = 3'd4
    } state_t;

    // Double-dabble correction: every BCD nibble of 5 or more gets +3.
    function automatic logic [BCD_W-1:0] dd_adjust(input logic [BCD_W-1:0] bcd);
        logic [BCD_W-1:0] res;
        res = bcd;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bcd[i*4 +: 4] >= 4'd5) begin
                res[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
            end else begin
                res[i*4 +: 4] = bcd[i*4 +: 4];
            end
        end
        return res;
    endfunction

    // Index (0 = most significant) of the first non-zero digit; the least
    // significant digit index is returned when all digits are zero.
    function automatic logic [IDX_W-1:0] first_sig_digit(input logic [BCD_W-1:0] bcd);
        logic [IDX_W-1:0] idx;
        idx = IDX_W'(NUM_DIGITS - 1);
        for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
            if (bcd[(NUM_DIGITS - 1 - i)*4 +: 4] != 4'd0) begin
                idx = IDX_W'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/freq_report_tx_bin2bcd.sv
// Sequential double-dabble binary-to-BCD converter: one shift per cycle,
// done is high during the 32nd shift cycle, result valid the cycle after.
module bin2bcd_seq
    import freq_report_tx_pkg::*;
(
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             start,
    input  logic [CNT_W-1:0] bin_in,
    output logic             done,
    output logic [BCD_W-1:0] bcd_out
);

    logic [CNT_W-1:0] shift_r;
    logic [BCD_W-1:0] bcd_r;
    logic [5:0]       iter_r;
    logic             run_r;
    logic [BCD_W-1:0] bcd_adj_s;
    logic             last_s;

    // Add-3 correction ahead of each shift and detection of the final shift.
    always_comb begin
        bcd_adj_s = dd_adjust(bcd_r);
        last_s    = run_r && (iter_r == 6'd31);
    end

    // Capture on start, then shift one input bit into the BCD register per cycle.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            shift_r <= '0;
            bcd_r   <= '0;
            iter_r  <= 6'd0;
            run_r   <= 1'b0;
        end else if (start) begin
            shift_r <= bin_in;
            bcd_r   <= '0;
            iter_r  <= 6'd0;
            run_r   <= 1'b1;
        end else if (run_r) begin
            bcd_r   <= {bcd_adj_s[BCD_W-2:0], shift_r[CNT_W-1]};
            shift_r <= {shift_r[CNT_W-2:0], 1'b0};
            iter_r  <= iter_r + 6'd1;
            run_r   <= !last_s;
        end else begin
            run_r   <= 1'b0;
        end
    end

    assign done    = last_s;
    assign bcd_out = bcd_r;

endmodule

// File: rtl/freq_report_tx.sv
// Frequency report transmitter: converts a 32-bit count to decimal ASCII and
// hands the bytes one at a time to a busy-flag UART transmitter.
module freq_report_tx
    import freq_report_tx_pkg::*;
#(
    parameter bit SUPPRESS_ZEROS = 1'b1,
    parameter bit SEND_CRLF      = 1'b1
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             cnt_valid,
    input  logic [CNT_W-1:0] cnt_value,
    output logic             uart_en,
    output logic [7:0]       uart_din,
    input  logic             uart_tx_busy,
    output logic             rpt_busy,
    output logic [7:0]       drop_cnt
);

    state_t           state_r, state_s;
    logic [IDX_W-1:0] idx_r, idx_s;
    logic             uart_en_r, uart_en_s;
    logic [7:0]       uart_din_r, uart_din_s;
    logic             rpt_busy_r;
    logic [7:0]       drop_cnt_r;
    logic             conv_start_s;
    logic             conv_done_s;
    logic [BCD_W-1:0] bcd_s;
    logic [IDX_W-1:0] start_idx_s;
    logic [IDX_W-1:0] pos_s;
    logic [IDX_W-1:0] last_pos_s;
    logic             last_byte_s;
    logic [5:0]       off_s;
    logic [7:0]       byte_s;

    bin2bcd_seq u_bin2bcd (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .start   (conv_start_s),
        .bin_in  (cnt_value),
        .done    (conv_done_s),
        .bcd_out (bcd_s)
    );

    // Byte selection: the start index skips leading zeros in one step, so the
    // frame position is simply start index plus the running byte index.
    always_comb begin
        if (SUPPRESS_ZEROS) begin
            start_idx_s = first_sig_digit(bcd_s);
        end else begin
            start_idx_s = '0;
        end
        if (SEND_CRLF) begin
            last_pos_s = 4'd11;
        end else begin
            last_pos_s = 4'd9;
        end
        pos_s       = start_idx_s + idx_r;
        last_byte_s = (pos_s == last_pos_s);
        off_s       = 6'd36 - {pos_s, 2'b00};
        case (pos_s)
            4'd10:   byte_s = ASCII_CR;
            4'd11:   byte_s = ASCII_LF;
            default: byte_s = ASCII_0 + {4'd0, bcd_s[off_s +: 4]};
        endcase
    end

    // Next-state and next-output logic of the report FSM.
    always_comb begin
        state_s      = state_r;
        idx_s        = idx_r;
        uart_en_s    = uart_en_r;
        uart_din_s   = uart_din_r;
        conv_start_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                uart_en_s = 1'b0;
                if (cnt_valid) begin
                    conv_start_s = 1'b1;
                    idx_s        = '0;
                    state_s      = ST_CONV;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CONV: begin
                if (conv_done_s) begin
                    state_s = ST_SEND_REQ;
                end else begin
                    state_s = ST_CONV;
                end
            end
            ST_SEND_REQ: begin
                // Never raise a request on top of a transmitter still busy.
                if (!uart_tx_busy) begin
                    uart_en_s  = 1'b1;
                    uart_din_s = byte_s;
                    state_s    = ST_SEND_WAIT;
                end else begin
                    state_s = ST_SEND_REQ;
                end
            end
            ST_SEND_WAIT: begin
                if (uart_tx_busy) begin
                    uart_en_s = 1'b0;
                    state_s   = ST_SEND_DONE;
                end else begin
                    state_s = ST_SEND_WAIT;
                end
            end
            ST_SEND_DONE: begin
                if (!uart_tx_busy) begin
                    if (last_byte_s) begin
                        state_s = ST_IDLE;
                    end else begin
                        idx_s   = idx_r + 4'd1;
                        state_s = ST_SEND_REQ;
                    end
                end else begin
                    state_s = ST_SEND_DONE;
                end
            end
            default: begin
                uart_en_s = 1'b0;
                state_s   = ST_IDLE;
            end
        endcase
    end

    // State, byte index and registered outputs.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_r    <= ST_IDLE;
            idx_r      <= '0;
            uart_en_r  <= 1'b0;
            uart_din_r <= 8'h00;
            rpt_busy_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            idx_r      <= idx_s;
            uart_en_r  <= uart_en_s;
            uart_din_r <= uart_din_s;
            rpt_busy_r <= (state_s != ST_IDLE);
        end
    end

    // Saturating count of strobes that arrive while a report is in progress.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            drop_cnt_r <= 8'd0;
        end else if (cnt_valid && (state_r != ST_IDLE) && (drop_cnt_r != 8'hFF)) begin
            drop_cnt_r <= drop_cnt_r + 8'd1;
        end else begin
            drop_cnt_r <= drop_cnt_r;
        end
    end

    assign uart_en  = uart_en_r;
    assign uart_din = uart_din_r;
    assign rpt_busy = rpt_busy_r;
    assign drop_cnt = drop_cnt_r;

endmodule

// File: tb/tb_freq_report_tx.sv
// Directed bench for freq_report_tx: one instance with zero suppression, one
// without, each driving its own behavioural busy-flag UART model.
module tb_freq_report_tx;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        cnt_valid;
    logic [31:0] cnt_value;
    logic        uart_en0, uart_en1;
    logic [7:0]  uart_din0, uart_din1;
    logic        busy0 = 1'b0, busy1 = 1'b0;
    logic        rpt_busy0, rpt_busy1;
    logic [7:0]  drop0, drop1;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic       prev_en0 = 1'b0, prev_en1 = 1'b0;
    int         dly0 = 0, dly1 = 0, bcnt0 = 0, bcnt1 = 0;
    int         fall_cyc0 = 0, fall_cyc1 = 0;
    logic [7:0] q0[$];
    logic [7:0] q1[$];

    always #5 sys_clk = ~sys_clk;

    freq_report_tx u_dut_sup (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .cnt_valid    (cnt_valid),
        .cnt_value    (cnt_value),
        .uart_en      (uart_en0),
        .uart_din     (uart_din0),
        .uart_tx_busy (busy0),
        .rpt_busy     (rpt_busy0),
        .drop_cnt     (drop0)
    );

    freq_report_tx #(.SUPPRESS_ZEROS(1'b0), .SEND_CRLF(1'b1)) u_dut_full (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .cnt_valid    (cnt_valid),
        .cnt_value    (cnt_value),
        .uart_en      (uart_en1),
        .uart_din     (uart_din1),
        .uart_tx_busy (busy1),
        .rpt_busy     (rpt_busy1),
        .drop_cnt     (drop1)
    );

    // Free-running edge counter.
    always @(posedge sys_clk) cyc <= cyc + 1;

    // UART model 0: capture byte on uart_en rise, busy 3 cycles later for 20 cycles.
    always @(posedge sys_clk) begin
        prev_en0 <= uart_en0;
        if (uart_en0 && !prev_en0) begin
            q0.push_back(uart_din0);
            dly0 <= 2;
        end else if (dly0 > 0) begin
            if (dly0 == 1) begin
                busy0 <= 1'b1;
                bcnt0 <= 20;
            end
            dly0 <= dly0 - 1;
        end else if (busy0) begin
            if (bcnt0 == 1) begin
                busy0     <= 1'b0;
                fall_cyc0 <= cyc;
            end
            bcnt0 <= bcnt0 - 1;
        end
    end

    // UART model 1: same behaviour for the non-suppressing instance.
    always @(posedge sys_clk) begin
        prev_en1 <= uart_en1;
        if (uart_en1 && !prev_en1) begin
            q1.push_back(uart_din1);
            dly1 <= 2;
        end else if (dly1 > 0) begin
            if (dly1 == 1) begin
                busy1 <= 1'b1;
                bcnt1 <= 20;
            end
            dly1 <= dly1 - 1;
        end else if (busy1) begin
            if (bcnt1 == 1) begin
                busy1     <= 1'b0;
                fall_cyc1 <= cyc;
            end
            bcnt1 <= bcnt1 - 1;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Compare a captured byte stream against the digit string followed by CR LF.
    task automatic check_frame(input string tag, input int which, input string digits);
        logic [7:0] exp_q[$];
        logic [7:0] got;
        int         n;
        for (int i = 0; i < digits.len(); i++) exp_q.push_back(digits[i]);
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
        n = (which == 0) ? q0.size() : q1.size();
        check_val($sformatf("%s dut%0d len", tag, which), n, exp_q.size());
        for (int i = 0; i < exp_q.size() && i < n; i++) begin
            got = (which == 0) ? q0[i] : q1[i];
            check_val($sformatf("%s dut%0d byte%0d", tag, which, i), 32'(got), 32'(exp_q[i]));
        end
    endtask

    // Send one value, optionally strobe cnt_valid during the frame, wait for both
    // instances to finish and check the frames and rpt_busy release timing.
    task automatic run_frame(input string tag, input logic [31:0] val, input string exp0,
                             input string exp1, input int n_drops, input int spacing,
                             output int en_k);
        int k;
        bit done;
        int rf0, rf1;
        q0.delete();
        q1.delete();
        @(negedge sys_clk);
        cnt_value = val;
        cnt_valid = 1'b1;
        @(negedge sys_clk);
        cnt_valid = 1'b0;
        cnt_value = 32'hDEAD_BEEF;
        check_val({tag, " accept"}, 32'({rpt_busy1, rpt_busy0}), 32'h3);
        k = 0; en_k = -1; done = 1'b0; rf0 = -1; rf1 = -1;
        while (!done && k < 3000) begin
            @(negedge sys_clk);
            k++;
            cnt_valid = (k >= 2) && (k < 2 + n_drops * spacing) && (((k - 2) % spacing) == 0);
            if (en_k < 0 && uart_en0) en_k = k;
            if (rf0 < 0 && !rpt_busy0) rf0 = cyc - 1;
            if (rf1 < 0 && !rpt_busy1) rf1 = cyc - 1;
            if (!rpt_busy0 && !rpt_busy1) done = 1'b1;
        end
        cnt_valid = 1'b0;
        check_val({tag, " finished"}, 32'(done), 32'h1);
        check_val({tag, " rpt_busy0 after busy"}, 32'(rf0 > fall_cyc0), 32'h1);
        check_val({tag, " rpt_busy1 after busy"}, 32'(rf1 > fall_cyc1), 32'h1);
        check_frame(tag, 0, exp0);
        check_frame(tag, 1, exp1);
    endtask

    // Watchdog so the run can never hang.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int en_k;
        int n0, n1;
        bit found;
        sys_rst   = 1'b1;
        cnt_valid = 1'b0;
        cnt_value = 32'd0;
        repeat (3) @(negedge sys_clk);
        check_val("reset uart_en",  32'({uart_en1, uart_en0}), 32'h0);
        check_val("reset uart_din0", 32'(uart_din0), 32'h0);
        check_val("reset uart_din1", 32'(uart_din1), 32'h0);
        check_val("reset rpt_busy", 32'({rpt_busy1, rpt_busy0}), 32'h0);
        check_val("reset drop0", 32'(drop0), 32'h0);
        check_val("reset drop1", 32'(drop1), 32'h0);
        sys_rst = 1'b0;

        run_frame("f10M", 32'd10000000, "10000000", "0010000000", 0, 1, en_k);
        run_frame("fzero", 32'd0, "0", "0000000000", 0, 1, en_k);
        run_frame("fmax", 32'hFFFF_FFFF, "4294967295", "4294967295", 0, 1, en_k);
        // 32 conversion cycles plus one SEND_REQ cycle before uart_en is seen.
        check_val("fmax conv latency", 32'(en_k), 32'd33);
        run_frame("f42", 32'd42, "42", "0000000042", 0, 1, en_k);
        check_val("no drops yet0", 32'(drop0), 32'd0);

        run_frame("fdrop3", 32'd7, "7", "0000000007", 3, 5, en_k);
        check_val("drop3 dut0", 32'(drop0), 32'd3);
        check_val("drop3 dut1", 32'(drop1), 32'd3);
        run_frame("fdrop300", 32'hFFFF_FFFF, "4294967295", "4294967295", 300, 1, en_k);
        check_val("drop sat dut0", 32'(drop0), 32'd255);
        check_val("drop sat dut1", 32'(drop1), 32'd255);

        // Reset in the middle of a frame, after the 4th byte's busy rises.
        q0.delete();
        q1.delete();
        @(negedge sys_clk);
        cnt_value = 32'd123456;
        cnt_valid = 1'b1;
        @(negedge sys_clk);
        cnt_valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 1000 && !found; i++) begin
            @(negedge sys_clk);
            if (q0.size() == 4 && busy0) found = 1'b1;
        end
        check_val("mid-frame 4th byte reached", 32'(found), 32'h1);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        check_val("rst uart_en", 32'({uart_en1, uart_en0}), 32'h0);
        check_val("rst uart_din0", 32'(uart_din0), 32'h0);
        check_val("rst uart_din1", 32'(uart_din1), 32'h0);
        check_val("rst rpt_busy", 32'({rpt_busy1, rpt_busy0}), 32'h0);
        check_val("rst drop0", 32'(drop0), 32'h0);
        check_val("rst drop1", 32'(drop1), 32'h0);
        sys_rst = 1'b0;
        n0 = q0.size();
        n1 = q1.size();
        repeat (100) @(negedge sys_clk);
        check_val("rst no more bytes0", 32'(q0.size()), 32'(n0));
        check_val("rst no more bytes1", 32'(q1.size()), 32'(n1));
        check_val("rst stays idle", 32'({rpt_busy1, rpt_busy0, uart_en1, uart_en0}), 32'h0);

        run_frame("fpost", 32'd9876, "9876", "0000009876", 0, 1, en_k);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/freq_report_tx.md
FREQ_REPORT_TX -- requirements
Module: freq_report_tx

Interface
REQ-001 Parameter SUPPRESS_ZEROS, default 1, meaning: 1 = strip leading zeros, keeping at least one digit; 0 = always send 10 digits.
REQ-002 Parameter SEND_CRLF, default 1, meaning: 1 = append 0x0D 0x0A after the digits.
REQ-003 sys_clk  input  1  single system clock; all logic is on the rising edge.
REQ-004 sys_rst  input  1  synchronous active-high reset.
REQ-005 cnt_valid  input  1  one-cycle strobe; cnt_value is valid in that cycle.
REQ-006 cnt_value  input  32  unsigned frequency count to report.
REQ-007 uart_en  output  1  send request level to the downstream UART transmitter.
REQ-008 uart_din  output  8  ASCII byte for the downstream transmitter.
REQ-009 uart_tx_busy  input  1  busy flag from the downstream transmitter.
REQ-010 rpt_busy  output  1  high from strobe acceptance until the last byte's busy falls.
REQ-011 drop_cnt  output  8  number of strobes dropped while rpt_busy, saturating.

Function
REQ-012 The block SHALL be a 5-state FSM: IDLE, CONV, SEND_REQ, SEND_WAIT, SEND_DONE.
- IDLE: cnt_valid captures cnt_value into a 32-bit shift register, clears a 40-bit BCD register and the iteration counter, and moves to CONV.
REQ-013 CONV SHALL run sequential double-dabble: one shift per cycle, exactly 32 cycles.
- Before each shift: add 3 to each BCD nibble that is >= 5.
- After the 32nd shift: the BCD register holds 10 digits, MSD first; the FSM moves to SEND_REQ.
REQ-014 Digit i SHALL map to ASCII 0x30 + nibble.
- With SUPPRESS_ZEROS=1: leading zero digits are skipped; the least significant digit is always sent.
- The skip is decided in SEND_REQ entry without spending extra cycles per skipped digit (priority-encoded start index).
REQ-015 SEND_REQ SHALL drive uart_din with the current byte and raise uart_en, then move to SEND_WAIT.
REQ-016 SEND_WAIT SHALL hold uart_en=1 and uart_din stable until uart_tx_busy=1.
- Then deassert uart_en and move to SEND_DONE.
- The downstream transmitter edge-detects uart_en through two flops, so busy is seen no earlier than 3 cycles after uart_en rises.
REQ-017 SEND_DONE SHALL wait for uart_tx_busy=0.
- If more bytes remain: advance the byte index and move to SEND_REQ.
- Otherwise: move to IDLE.
REQ-018 Byte sequence: the digits, then 0x0D and 0x0A if SEND_CRLF=1.
- Maximum frame: 12 bytes.
- Byte index width: 4 bits.
REQ-019 rpt_busy SHALL be 1 in every state except IDLE; it is registered.
REQ-020 cnt_valid while rpt_busy=1 SHALL be ignored and SHALL increment drop_cnt.
- drop_cnt saturates at 255 and never wraps.
REQ-021 cnt_valid in the same cycle the FSM returns to IDLE SHALL be dropped; acceptance occurs only while in IDLE.
REQ-022 uart_en SHALL never rise while uart_tx_busy=1 at entry to SEND_REQ.
- If busy is already high at entry, SEND_REQ waits (uart_en=0) until it is low.
REQ-023 All outputs SHALL be registered; there are no combinational paths from inputs to outputs.

Reset
REQ-024 sys_rst=1 SHALL force, on the next rising edge:
- the FSM to IDLE;
- uart_en=0, uart_din=0x00, rpt_busy=0, drop_cnt=0;
- the BCD, shift and index registers to 0.
REQ-025 Reset asserted mid-conversion or mid-frame SHALL abandon the frame with no further bytes; uart_en is low the cycle after reset.

Structure
REQ-026 A shared package SHALL hold:
- the FSM state encoding;
- ASCII constants (ASCII_0=0x30, ASCII_CR=0x0D, ASCII_LF=0x0A);
- NUM_DIGITS=10 and the 32-bit input width.
REQ-027 The double-dabble engine SHALL be one sub-module, bin2bcd_seq.
- Interface: start/done handshake, 32-bit in, 40-bit out, fixed 32-cycle latency from start to done.
- The top module holds the FSM, the byte sequencer and the counters.

Verification
REQ-028 The bench SHALL use a behavioural UART model asserting busy 3 cycles after the uart_en rise for 20 cycles. The bench SHALL cover:
- cnt_value=10000000, SUPPRESS_ZEROS=1 -> bytes 31 30 30 30 30 30 30 30 0D 0A; rpt_busy falls after the last busy falls.
- cnt_value=0 -> bytes 30 0D 0A exactly.
- cnt_value=0xFFFFFFFF -> 34 32 39 34 39 36 37 32 39 35 0D 0A; the CONV phase lasts exactly 32 cycles.
- SUPPRESS_ZEROS=0, cnt_value=42 -> 30 30 30 30 30 30 30 30 34 32 0D 0A.
- Three cnt_valid pulses during a frame -> drop_cnt=3; the frame is unaffected; 300 dropped pulses -> drop_cnt=255.
- sys_rst pulsed after the 4th byte's busy rises -> uart_en=0 next cycle, no further bytes, all outputs at reset values; the next cnt_valid yields a complete correct frame.
